aes_job_arbiter: RTL and testbench

AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

---
 rtl/aes_job_arbiter.sv | 114 +++++++++++
 tb/tb_aes_job_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_arbiter.sv
// Two-requester round-robin arbiter that runs one AES decrypt job at a time.
// Latches the winner's key/message, drives the core handshake and returns a DONE or ERR pulse.
module aes_job_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic [127:0] KEY0,
  input  logic [127:0] KEY1,
  input  logic [127:0] MSG0,
  input  logic [127:0] MSG1,
  output logic         DONE0,
  output logic         DONE1,
  output logic         ERR0,
  output logic         ERR1,
  output logic [127:0] RESULT,
  output logic         BUSY,
  output logic         OWNER,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC
);

  localparam int unsigned     CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StClear,
    StResp
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_last;
  logic [127:0]      r_key;
  logic [127:0]      r_msg;
  logic [127:0]      r_result;
  logic [CntW-1:0]   r_cnt;
  logic              r_err;

  logic              w_any_req;
  logic              w_grant;
  logic              w_resp;

  assign w_any_req = REQ0 | REQ1;
  // On a tie the requester not granted last wins; a lone request always wins.
  assign w_grant   = (REQ0 & REQ1) ? ~r_last : REQ1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= StIdle;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_key    <= '0;
      r_msg    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state <= StLoad;
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_key   <= w_grant ? KEY1 : KEY0;
            r_msg   <= w_grant ? MSG1 : MSG0;
            r_cnt   <= '0;
          end
        end
        StLoad: r_state <= StRun;
        StRun: begin
          r_cnt <= r_cnt + CntW'(1);
          // Success has priority over a timeout landing on the same edge.
          if (AES_DONE) begin
            r_result <= AES_MSG_DEC;
            r_state  <= StClear;
          end else if (r_cnt == LastCnt) begin
            r_err   <= 1'b1;
            r_state <= StClear;
          end
        end
        StClear: begin
          if (!AES_DONE) r_state <= StResp;
        end
        StResp: begin
          r_err   <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_resp      = (r_state == StResp);
  assign BUSY        = (r_state != StIdle);
  assign AES_START   = (r_state == StRun);
  assign DONE0       = w_resp & ~r_err & ~r_owner;
  assign DONE1       = w_resp & ~r_err &  r_owner;
  assign ERR0        = w_resp &  r_err & ~r_owner;
  assign ERR1        = w_resp &  r_err &  r_owner;
  assign RESULT      = r_result;
  assign OWNER       = r_owner;
  assign AES_KEY     = r_key;
  assign AES_MSG_ENC = r_msg;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter: an AES core model with programmable latency and a response
// scoreboard; expected responses are queued when a request is raised.
module tb_aes_job_arbiter;

  localparam int unsigned   TimeoutCycles = 16;
  localparam logic [127:0]  VecKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0]  VecCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0]  VecPt  = 128'h00112233445566778899aabbccddeeff;

  logic         CLK, RESET, REQ0, REQ1;
  logic [127:0] KEY0, KEY1, MSG0, MSG1;
  logic         DONE0, DONE1, ERR0, ERR1, BUSY, OWNER, AES_START, AES_DONE;
  logic [127:0] RESULT, AES_KEY, AES_MSG_ENC, AES_MSG_DEC;

  typedef struct packed {
    logic         owner;
    logic         err;
    logic [127:0] result;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  logic [127:0] last_result = '0;

  // Core model controls: done on the m_n-th RUN cycle, held m_hold extra cycles.
  int m_n = 10;
  int m_hold = 0;
  bit m_en = 1'b1;
  int m_cnt = 0;
  int m_left = 0;

  aes_job_arbiter #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1),
    .KEY0(KEY0), .KEY1(KEY1), .MSG0(MSG0), .MSG1(MSG1),
    .DONE0(DONE0), .DONE1(DONE1), .ERR0(ERR0), .ERR1(ERR1),
    .RESULT(RESULT), .BUSY(BUSY), .OWNER(OWNER),
    .AES_START(AES_START), .AES_DONE(AES_DONE), .AES_KEY(AES_KEY),
    .AES_MSG_ENC(AES_MSG_ENC), .AES_MSG_DEC(AES_MSG_DEC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] c);
    if (k == VecKey && c == VecCt) return VecPt;
    return c ^ {k[63:0], k[127:64]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // AES core model
  initial begin
    AES_DONE    = 1'b0;
    AES_MSG_DEC = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (AES_DONE && m_left > 0) m_left--;
      else AES_DONE = 1'b0;
      if (!AES_DONE) AES_MSG_DEC = rnd128();
      if (AES_START) begin
        m_cnt++;
        if (m_en && m_cnt == m_n) begin
          AES_DONE    = 1'b1;
          m_left      = m_hold;
          AES_MSG_DEC = aes_dec(AES_KEY, AES_MSG_ENC);
        end
      end else begin
        m_cnt = 0;
      end
    end
  end

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    last_result = '0;
  endtask

  // Waits (bounded) for a DONE/ERR pulse and reports what was seen; no checking here.
  task automatic wait_resp(output bit got, output logic own_line, output logic err_seen,
                           output logic own_port, output logic [127:0] res,
                           output int n_hot, output int start_cyc, output int clear_cyc);
    bit run_seen;
    run_seen = 1'b0;
    got = 1'b0; own_line = 1'b0; err_seen = 1'b0; own_port = 1'b0; res = '0;
    n_hot = 0; start_cyc = 0; clear_cyc = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge CLK);
      if (AES_START) begin
        start_cyc++;
        run_seen = 1'b1;
      end else if (DONE0 | DONE1 | ERR0 | ERR1) begin
        got      = 1'b1;
        n_hot    = int'(DONE0) + int'(DONE1) + int'(ERR0) + int'(ERR1);
        own_line = DONE1 | ERR1;
        err_seen = ERR0 | ERR1;
        own_port = OWNER;
        res      = RESULT;
      end else if (run_seen && BUSY) begin
        clear_cyc++;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #1;
    RESET = 1'b1;
    #1;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    total++;
    if (AES_START !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", AES_START); end
    total++;
    if ({DONE0, DONE1, ERR0, ERR1} !== 4'b0) begin
      bad++; $display("FAIL reset_pulses got=%b want=0000", {DONE0, DONE1, ERR0, ERR1});
    end
    total++; if (OWNER !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b want=0", OWNER); end
    total++;
    if (RESULT !== 128'h0) begin bad++; $display("FAIL reset_result got=%h want=0", RESULT); end
    total++;
    if ({AES_KEY, AES_MSG_ENC} !== 256'h0) begin
      bad++; $display("FAIL reset_job_regs got=%h/%h want=0", AES_KEY, AES_MSG_ENC);
    end
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Vector job; DONE0 must sit in cycle 13 counting the LOAD cycle as cycle 1.
  task automatic test_single();
    int   first_done, done_cnt, other;
    exp_t ex;
    first_done = 0; done_cnt = 0; other = 0;
    m_en = 1'b1; m_n = 10; m_hold = 0;
    KEY0 = VecKey; MSG0 = VecCt; KEY1 = rnd128(); MSG1 = rnd128();
    @(negedge CLK);
    REQ0 = 1'b1;
    exp_q.push_back('{owner: 1'b0, err: 1'b0, result: VecPt});
    @(posedge CLK);
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        total++;
        if (OWNER !== 1'b0) begin bad++; $display("FAIL single_owner got=%b want=0", OWNER); end
        total++;
        if (AES_KEY !== VecKey || AES_MSG_ENC !== VecCt) begin
          bad++; $display("FAIL single_latch got=%h/%h want=%h/%h", AES_KEY, AES_MSG_ENC,
                          VecKey, VecCt);
        end
        total++;
        if (AES_START !== 1'b0) begin bad++; $display("FAIL single_load_start got=1 want=0"); end
        KEY0 = rnd128();
        MSG0 = rnd128();
      end
      if (c == 2) begin
        total++;
        if (AES_START !== 1'b1) begin bad++; $display("FAIL single_run_start got=0 want=1"); end
      end
      if (c == 6) begin
        total++;
        if (AES_KEY !== VecKey || AES_MSG_ENC !== VecCt) begin
          bad++; $display("FAIL single_isolation got=%h/%h want=%h/%h", AES_KEY, AES_MSG_ENC,
                          VecKey, VecCt);
        end
      end
      if (DONE0 === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
        REQ0 = 1'b0;
      end
      if (DONE1 === 1'b1 || ERR0 === 1'b1 || ERR1 === 1'b1) other++;
    end
    ex = exp_q.pop_front();
    total++;
    if (first_done != 13) begin bad++; $display("FAIL single_latency got=%0d want=13", first_done); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
    total++;
    if (other != 0) begin bad++; $display("FAIL single_other_pulses got=%0d want=0", other); end
    total++;
    if (RESULT !== ex.result) begin
      bad++; $display("FAIL single_result got=%h want=%h", RESULT, ex.result);
    end
    last_result = ex.result;
  endtask

  task automatic test_round_robin();
    bit got; logic ol, er, op; logic [127:0] res; int nh, sc, cc;
    exp_t ex;
    apply_reset();
    m_en = 1'b1; m_n = 3; m_hold = 0;
    KEY0 = rnd128(); MSG0 = rnd128(); KEY1 = rnd128(); MSG1 = rnd128();
    @(negedge CLK);
    REQ0 = 1'b1; REQ1 = 1'b1;
    exp_q.push_back('{owner: 1'b0, err: 1'b0, result: aes_dec(KEY0, MSG0)});
    exp_q.push_back('{owner: 1'b1, err: 1'b0, result: aes_dec(KEY1, MSG1)});
    exp_q.push_back('{owner: 1'b0, err: 1'b0, result: aes_dec(KEY0, MSG0)});
    for (int i = 0; i < 3; i++) begin
      wait_resp(got, ol, er, op, res, nh, sc, cc);
      if (i == 2) begin REQ0 = 1'b0; REQ1 = 1'b0; end
      ex = exp_q.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL rr_timeout job=%0d got=none want=pulse", i); end
      total++;
      if (ol !== ex.owner || op !== ex.owner) begin
        bad++; $display("FAIL rr_owner job=%0d got=line%b/port%b want=%b", i, ol, op, ex.owner);
      end
      total++;
      if (er !== ex.err || nh != 1) begin
        bad++; $display("FAIL rr_pulse job=%0d got=err%b hot%0d want=err%b hot1", i, er, nh,
                        ex.err);
      end
      total++;
      if (res !== ex.result) begin
        bad++; $display("FAIL rr_result job=%0d got=%h want=%h", i, res, ex.result);
      end
      last_result = ex.result;
    end
  endtask

  task automatic test_timeout();
    bit got; logic ol, er, op; logic [127:0] res; int nh, sc, cc;
    exp_t ex;
    m_en = 1'b0;
    KEY0 = rnd128(); MSG0 = rnd128();
    @(negedge CLK);
    REQ0 = 1'b1;
    exp_q.push_back('{owner: 1'b0, err: 1'b1, result: last_result});
    wait_resp(got, ol, er, op, res, nh, sc, cc);
    REQ0 = 1'b0;
    ex = exp_q.pop_front();
    total++;
    if (!got || sc != 16) begin
      bad++; $display("FAIL timeout_start_cycles got=%0d (resp=%b) want=16", sc, got);
    end
    total++;
    if (er !== ex.err || ol !== ex.owner || nh != 1) begin
      bad++; $display("FAIL timeout_err got=err%b own%b hot%0d want=err1 own0 hot1", er, ol, nh);
    end
    total++;
    if (res !== ex.result) begin bad++; $display("FAIL timeout_result got=%h want=%h", res, ex.result); end
    @(negedge CLK);
    total++;
    if (ERR0 !== 1'b0) begin bad++; $display("FAIL timeout_err_width got=1 want=0"); end
    m_en = 1'b1;
  endtask

  task automatic test_collision();
    bit got; logic ol, er, op; logic [127:0] res; int nh, sc, cc;
    exp_t ex;
    m_en = 1'b1; m_n = 16; m_hold = 0;
    KEY1 = rnd128(); MSG1 = rnd128();
    @(negedge CLK);
    REQ1 = 1'b1;
    exp_q.push_back('{owner: 1'b1, err: 1'b0, result: aes_dec(KEY1, MSG1)});
    wait_resp(got, ol, er, op, res, nh, sc, cc);
    REQ1 = 1'b0;
    ex = exp_q.pop_front();
    total++;
    if (!got || sc != 16) begin
      bad++; $display("FAIL collide_start_cycles got=%0d (resp=%b) want=16", sc, got);
    end
    total++;
    if (er !== ex.err || ol !== ex.owner || nh != 1) begin
      bad++; $display("FAIL collide_pulse got=err%b own%b hot%0d want=err0 own1 hot1", er, ol, nh);
    end
    total++;
    if (res !== ex.result) begin bad++; $display("FAIL collide_result got=%h want=%h", res, ex.result); end
    last_result = ex.result;
  endtask

  // Core holds DONE 4 cycles past START; CLEAR lasts those 4 plus the one sampling it low.
  task automatic test_sticky_done();
    bit got; logic ol, er, op; logic [127:0] res; int nh, sc, cc;
    exp_t ex;
    m_en = 1'b1; m_n = 4; m_hold = 4;
    KEY0 = rnd128(); MSG0 = rnd128();
    @(negedge CLK);
    REQ0 = 1'b1;
    exp_q.push_back('{owner: 1'b0, err: 1'b0, result: aes_dec(KEY0, MSG0)});
    wait_resp(got, ol, er, op, res, nh, sc, cc);
    REQ0 = 1'b0;
    m_hold = 0;
    ex = exp_q.pop_front();
    total++;
    if (!got || cc != 5 || sc != 4) begin
      bad++; $display("FAIL sticky_clear got=clear%0d run%0d want=clear5 run4", cc, sc);
    end
    total++;
    if (er !== ex.err || ol !== ex.owner || res !== ex.result) begin
      bad++; $display("FAIL sticky_resp got=err%b own%b %h want=err0 own0 %h", er, ol, res,
                      ex.result);
    end
    last_result = ex.result;
  endtask

  task automatic test_reset_mid_run();
    bit got; logic ol, er, op; logic [127:0] res; int nh, sc, cc;
    int   runs, pulses;
    exp_t ex;
    runs = 0; pulses = 0;
    m_en = 1'b0;
    KEY0 = rnd128(); MSG0 = rnd128();
    @(negedge CLK);
    REQ0 = 1'b1;
    for (int i = 0; i < 40 && runs < 5; i++) begin
      @(negedge CLK);
      if (AES_START === 1'b1) runs++;
    end
    #2;
    RESET = 1'b1;
    #1;
    total++;
    if (runs != 5 || AES_START !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL midrst_async got=runs%0d start%b busy%b want=runs5 start0 busy0",
                      runs, AES_START, BUSY);
    end
    total++;
    if (RESULT !== 128'h0 || OWNER !== 1'b0) begin
      bad++; $display("FAIL midrst_regs got=%h own%b want=0 own0", RESULT, OWNER);
    end
    REQ0 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    last_result = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DONE0 | DONE1 | ERR0 | ERR1) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL midrst_no_pulse got=%0d want=0", pulses); end
    m_en = 1'b1; m_n = 2;
    KEY0 = rnd128(); MSG0 = rnd128(); KEY1 = rnd128(); MSG1 = rnd128();
    REQ0 = 1'b1; REQ1 = 1'b1;
    exp_q.push_back('{owner: 1'b0, err: 1'b0, result: aes_dec(KEY0, MSG0)});
    wait_resp(got, ol, er, op, res, nh, sc, cc);
    REQ0 = 1'b0; REQ1 = 1'b0;
    ex = exp_q.pop_front();
    total++;
    if (!got || ol !== ex.owner || op !== ex.owner) begin
      bad++; $display("FAIL midrst_tie got=line%b/port%b (resp=%b) want=0", ol, op, got);
    end
    total++;
    if (er !== ex.err || res !== ex.result) begin
      bad++; $display("FAIL midrst_result got=err%b %h want=err0 %h", er, res, ex.result);
    end
    @(negedge CLK);
  endtask

  initial begin
    REQ0 = 1'b0; REQ1 = 1'b0;
    KEY0 = '0; KEY1 = '0; MSG0 = '0; MSG1 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_collision();
    test_sticky_done();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
